// File: rtl/tdm_pkg.sv
// Shared constants and types for the four-slot TDM demultiplexer.
package tdm_pkg;
   localparam int SLOTS = 4;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } tdm_state_t;

   typedef logic [$clog2(SLOTS)-1:0] slot_t;
endpackage

// File: rtl/tdm_chan_shift.sv
// Per-channel MSB-first accumulator. With clr and shift_en together, the
// register restarts as a fresh word holding only the incoming bit.
module tdm_chan_shift #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         shift_en,
   input  logic         din,
   output logic [W-1:0] q
);
   logic [W-2:0] kept;

   assign kept = clr ? '0 : q[W-2:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (shift_en) begin
         q <= {kept, din};
      end else if (clr) begin
         q <= '0;
      end
   end
endmodule

// File: rtl/tdm_demux4.sv
// Serial four-slot TDM demultiplexer with frame-sync lock, word assembly
// and a valid/ready output handshake with a sticky overrun flag.
//
// state  | meaning
// HUNT   | waiting for an en cycle with frame_sync=1 to start a frame
// LOCKED | assembling words; frame_sync must appear at slot 0 and only there
module tdm_demux4
   import tdm_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         din,
   input  logic         frame_sync,
   input  logic         en,
   input  logic         out_ready,
   output logic [W-1:0] y0,
   output logic [W-1:0] y1,
   output logic [W-1:0] y2,
   output logic [W-1:0] y3,
   output logic         out_valid,
   output logic [1:0]   sel,
   output logic         sync_err,
   output logic         overrun
);
   localparam int CW = (W > 1) ? $clog2(W) : 1;

   tdm_state_t       state, state_nx;
   slot_t            sel_q, sel_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic [SLOTS-1:0] sh_en;
   logic             clr_all, err, complete;
   logic [W-1:0]     q [SLOTS];
   logic [W-1:0]     last_word;

   assign sel = sel_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= HUNT;
         sel_q <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         sel_q <= sel_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      sel_nx   = sel_q;
      cnt_nx   = cnt;
      sh_en    = '0;
      clr_all  = 1'b0;
      err      = 1'b0;
      complete = 1'b0;
      if (en) begin
         case (state)
            HUNT: begin
               if (frame_sync) begin
                  clr_all  = 1'b1;
                  sh_en[0] = 1'b1;
                  sel_nx   = slot_t'(1);
                  cnt_nx   = '0;
                  state_nx = LOCKED;
               end
            end
            LOCKED: begin
               if (frame_sync && sel_q != '0) begin
                  // Misplaced sync: restart the frame on this very bit.
                  err      = 1'b1;
                  clr_all  = 1'b1;
                  sh_en[0] = 1'b1;
                  sel_nx   = slot_t'(1);
                  cnt_nx   = '0;
               end else if (!frame_sync && sel_q == '0) begin
                  err      = 1'b1;
                  clr_all  = 1'b1;
                  sel_nx   = '0;
                  cnt_nx   = '0;
                  state_nx = HUNT;
               end else begin
                  sh_en[sel_q] = 1'b1;
                  sel_nx       = sel_q + slot_t'(1);
                  if (sel_q == slot_t'(SLOTS - 1)) begin
                     if (cnt == CW'(W - 1)) begin
                        complete = 1'b1;
                        cnt_nx   = '0;
                     end else begin
                        cnt_nx = cnt + CW'(1);
                     end
                  end
               end
            end
            default: state_nx = HUNT;
         endcase
      end
   end

   for (genvar i = 0; i < SLOTS; i++) begin : g_chan
      tdm_chan_shift #(.W(W)) u_chan (
         .clk      (clk),
         .rst_n    (rst_n),
         .clr      (clr_all),
         .shift_en (sh_en[i]),
         .din      (din),
         .q        (q[i])
      );
   end

   // Slot 3's final bit is not in its register yet when the word set completes.
   assign last_word = {q[SLOTS-1][W-2:0], din};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y0        <= '0;
         y1        <= '0;
         y2        <= '0;
         y3        <= '0;
         out_valid <= 1'b0;
         sync_err  <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         sync_err <= err;
         if (complete && (!out_valid || out_ready)) begin
            y0        <= q[0];
            y1        <= q[1];
            y2        <= q[2];
            y3        <= last_word;
            out_valid <= 1'b1;
         end else begin
            if (complete) overrun <= 1'b1;
            if (out_valid && out_ready) out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 (W=8).
module tb_tdm_demux4;
   logic       clk = 1'b0;
   logic       rst_n, din, frame_sync, en, out_ready;
   logic [7:0] y0, y1, y2, y3;
   logic       out_valid, sync_err, overrun;
   logic [1:0] sel;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   tdm_demux4 #(.W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .frame_sync (frame_sync),
      .en         (en),
      .out_ready  (out_ready),
      .y0         (y0),
      .y1         (y1),
      .y2         (y2),
      .y3         (y3),
      .out_valid  (out_valid),
      .sel        (sel),
      .sync_err   (sync_err),
      .overrun    (overrun)
   );

   initial begin
      #300000;
      $display("FAIL watchdog: time limit expired, required finish before 300000");
      $fatal(1, "watchdog");
   end

   task automatic step(input logic e, input logic f, input logic d);
      en = e;
      frame_sync = f;
      din = d;
      @(posedge clk);
      #1;
   endtask

   // Drives frames k0..7 of four words; reports out_valid activity and gap sel slips.
   task automatic send_frames(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              input logic [7:0] d, input int k0, input bit gaps,
                              input bit rdy_last, output int vcnt, output bit v_last,
                              output int sel_bad);
      logic [7:0] w [4];
      w = '{a, b, c, d};
      vcnt = 0;
      v_last = 1'b0;
      sel_bad = 0;
      for (int k = k0; k < 8; k++) begin
         for (int s = 0; s < 4; s++) begin
            if (gaps) begin
               repeat ($urandom_range(0, 2)) begin
                  step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                  if (sel !== 2'(s)) sel_bad++;
                  if (out_valid === 1'b1) vcnt++;
               end
            end
            if (rdy_last && k == 7 && s == 3) out_ready = 1'b1;
            step(1'b1, s == 0, w[s][7-k]);
            if (out_valid === 1'b1) vcnt++;
         end
      end
      v_last = out_valid;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; en = 1'b0; frame_sync = 1'b0; din = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({y0, y1, y2, y3} !== 32'h0) begin bad++; $display("FAIL reset_y: got %h want 0", {y0, y1, y2, y3}); end
      total++;
      if ({out_valid, sync_err, overrun, sel} !== 5'b0) begin
         bad++; $display("FAIL reset_flags: got %b want 00000", {out_valid, sync_err, overrun, sel});
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_nominal;
      int vc, sb; bit vl;
      out_ready = 1'b1;
      step(1'b1, 1'b0, 1'b1);
      total++;
      if (sel !== 2'd0) begin bad++; $display("FAIL hunt_ignore: sel got %0d want 0", sel); end
      send_frames(8'hA5, 8'h3C, 8'hFF, 8'h00, 0, 1'b0, 1'b0, vc, vl, sb);
      total++;
      if (vc !== 1 || vl !== 1'b1) begin bad++; $display("FAIL nominal_valid: count %0d last %0b want 1 1", vc, vl); end
      total++;
      if ({y0, y1, y2, y3} !== 32'hA53CFF00) begin bad++; $display("FAIL nominal_words: got %h want a53cff00", {y0, y1, y2, y3}); end
      total++;
      if (sel !== 2'd0) begin bad++; $display("FAIL nominal_sel: got %0d want 0", sel); end
      step(1'b0, 1'b0, 1'b0);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL nominal_clear: out_valid %0b want 0", out_valid); end
      total++;
      if ({y0, y1, y2, y3} !== 32'hA53CFF00) begin bad++; $display("FAIL nominal_hold: got %h want a53cff00", {y0, y1, y2, y3}); end
   endtask

   task automatic test_gaps;
      int vc, sb; bit vl;
      send_frames(8'hA5, 8'h3C, 8'hFF, 8'h00, 0, 1'b1, 1'b0, vc, vl, sb);
      total++;
      if (sb !== 0) begin bad++; $display("FAIL gaps_sel: %0d gap cycles moved sel, want 0", sb); end
      total++;
      if (vc !== 1 || vl !== 1'b1) begin bad++; $display("FAIL gaps_valid: count %0d last %0b want 1 1", vc, vl); end
      total++;
      if ({y0, y1, y2, y3} !== 32'hA53CFF00) begin bad++; $display("FAIL gaps_words: got %h want a53cff00", {y0, y1, y2, y3}); end
      step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_backpressure;
      int vc, sb; bit vl;
      out_ready = 1'b0;
      send_frames(8'h11, 8'h22, 8'h33, 8'h44, 0, 1'b0, 1'b0, vc, vl, sb);
      total++;
      if (vc !== 1 || vl !== 1'b1 || overrun !== 1'b0) begin
         bad++; $display("FAIL bp_first: count %0d last %0b overrun %0b want 1 1 0", vc, vl, overrun);
      end
      send_frames(8'h55, 8'h66, 8'h77, 8'h88, 0, 1'b0, 1'b0, vc, vl, sb);
      total++;
      if (vc !== 32 || overrun !== 1'b1) begin bad++; $display("FAIL bp_overrun: count %0d overrun %0b want 32 1", vc, overrun); end
      total++;
      if ({y0, y1, y2, y3} !== 32'h11223344) begin bad++; $display("FAIL bp_retain: got %h want 11223344", {y0, y1, y2, y3}); end
      out_ready = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      total++;
      if (out_valid !== 1'b0 || {y0, y1, y2, y3} !== 32'h11223344) begin
         bad++; $display("FAIL bp_transfer: valid %0b y %h want 0 11223344", out_valid, {y0, y1, y2, y3});
      end
      out_ready = 1'b0;
      send_frames(8'h12, 8'h34, 8'h56, 8'h78, 0, 1'b0, 1'b0, vc, vl, sb);
      send_frames(8'h9A, 8'hBC, 8'hDE, 8'hF0, 0, 1'b0, 1'b1, vc, vl, sb);
      total++;
      if (vl !== 1'b1 || {y0, y1, y2, y3} !== 32'h9ABCDEF0) begin
         bad++; $display("FAIL bp_same_edge: valid %0b y %h want 1 9abcdef0", vl, {y0, y1, y2, y3});
      end
      step(1'b0, 1'b0, 1'b0);
      total++;
      if (out_valid !== 1'b0 || overrun !== 1'b1) begin
         bad++; $display("FAIL bp_after: valid %0b overrun %0b want 0 1", out_valid, overrun);
      end
   endtask

   task automatic test_misaligned;
      int vc, sb; bit vl;
      logic [7:0] c [4];
      c = '{8'h5A, 8'h0F, 8'h81, 8'h7E};
      for (int i = 0; i < 14; i++) step(1'b1, (i % 4) == 0, 1'b1);
      total++;
      if (sel !== 2'd2 || sync_err !== 1'b0) begin bad++; $display("FAIL mis_pre: sel %0d err %0b want 2 0", sel, sync_err); end
      step(1'b1, 1'b1, c[0][7]);
      total++;
      if (sync_err !== 1'b1 || sel !== 2'd1) begin bad++; $display("FAIL mis_pulse: err %0b sel %0d want 1 1", sync_err, sel); end
      step(1'b1, 1'b0, c[1][7]);
      total++;
      if (sync_err !== 1'b0) begin bad++; $display("FAIL mis_width: err %0b want 0", sync_err); end
      step(1'b1, 1'b0, c[2][7]);
      step(1'b1, 1'b0, c[3][7]);
      send_frames(c[0], c[1], c[2], c[3], 1, 1'b0, 1'b0, vc, vl, sb);
      total++;
      if (vc !== 1 || vl !== 1'b1 || {y0, y1, y2, y3} !== 32'h5A0F817E) begin
         bad++; $display("FAIL mis_words: count %0d last %0b y %h want 1 1 5a0f817e", vc, vl, {y0, y1, y2, y3});
      end
   endtask

   task automatic test_missing_sync;
      int vc, sb; bit vl;
      for (int s = 0; s < 4; s++) step(1'b1, s == 0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      total++;
      if (sync_err !== 1'b1 || sel !== 2'd0 || out_valid !== 1'b0) begin
         bad++; $display("FAIL miss_pulse: err %0b sel %0d valid %0b want 1 0 0", sync_err, sel, out_valid);
      end
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
      total++;
      if (sync_err !== 1'b0 || sel !== 2'd0) begin bad++; $display("FAIL miss_hunt: err %0b sel %0d want 0 0", sync_err, sel); end
      send_frames(8'hE1, 8'h2D, 8'hB4, 8'h69, 0, 1'b0, 1'b0, vc, vl, sb);
      total++;
      if (vc !== 1 || vl !== 1'b1 || {y0, y1, y2, y3} !== 32'hE12DB469) begin
         bad++; $display("FAIL miss_relock: count %0d last %0b y %h want 1 1 e12db469", vc, vl, {y0, y1, y2, y3});
      end
      total++;
      if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky: got %0b want 1", overrun); end
   endtask

   task automatic test_reset_midframe;
      int vc, sb; bit vl;
      out_ready = 1'b0;
      for (int s = 0; s < 3; s++) step(1'b1, s == 0, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({y0, y1, y2, y3} !== 32'h0 || {out_valid, sync_err, overrun, sel} !== 5'b0) begin
         bad++; $display("FAIL async_reset: y %h flags %b want 0 00000", {y0, y1, y2, y3}, {out_valid, sync_err, overrun, sel});
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      step(1'b1, 1'b0, 1'b1);
      send_frames(8'hC3, 8'h96, 8'h01, 8'h80, 0, 1'b0, 1'b0, vc, vl, sb);
      total++;
      if (vc !== 1 || vl !== 1'b1 || {y0, y1, y2, y3} !== 32'hC3960180) begin
         bad++; $display("FAIL reset_restart: count %0d last %0b y %h want 1 1 c3960180", vc, vl, {y0, y1, y2, y3});
      end
   endtask

   initial begin
      test_reset;
      test_nominal;
      test_gaps;
      test_backpressure;
      test_misaligned;
      test_missing_sync;
      test_reset_midframe;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
